// File: rtl/pipe_pkg.sv
// pipe_pkg: constants and types shared by the 4-stage pipeline issue logic.
//   NREG - number of architectural registers
//   AW   - register address width
//   LW   - in-flight latency counter width (max latency 2^LW-1)
//   CW   - stall counter width
package pipe_pkg;
    localparam int NREG = 8;
    localparam int AW   = 3;
    localparam int LW   = 2;
    localparam int CW   = 16;

    typedef logic [AW-1:0] reg_addr_t;
endpackage

// File: rtl/hazard_interlock_scoreboard_entry.sv
// scoreboard_entry: one in-flight-write slot for a single architectural register.
// Holds a down-counter of cycles until the pending result becomes forwardable.
// Ports:
//   i_clk      - clock, rising edge
//   i_reset    - asynchronous active-high clear
//   i_load     - load i_load_val (takes priority over the decrement)
//   i_load_val - latency to load
//   o_busy     - counter is non-zero (write pending, not yet forwardable)
module scoreboard_entry
    import pipe_pkg::*;
#(
    parameter int CNT_W = LW
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_busy
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_interlock.sv
// hazard_interlock: issue-side scoreboard covering results that have not yet
// reached the writeback forwarding path. Raises o_stall when the instruction in
// decode reads (RAW) or overwrites (WAW) a register with a pending write.
// Ports:
//   i_clk, i_reset         - clock; asynchronous active-high reset
//   i_issue_valid          - instruction in decode presents for issue
//   i_issue_rd             - destination register
//   i_issue_regwrite       - instruction writes i_issue_rd
//   i_issue_lat            - cycles until its result is forwardable (0 = no entry)
//   i_src_a/_used          - first source register and its use flag
//   i_src_b/_used          - second source register and its use flag
//   i_flush                - kill the instruction in decode
//   o_stall                - hold decode/fetch this cycle (combinational)
//   o_busy_vec             - per-register pending-write flags (state only)
//   o_stall_count          - saturating count of stalled cycles
module hazard_interlock #(
    parameter int NREG = pipe_pkg::NREG,
    parameter int AW   = pipe_pkg::AW,
    parameter int LW   = pipe_pkg::LW,
    parameter int CW   = pipe_pkg::CW
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_issue_valid,
    input  logic [AW-1:0]   i_issue_rd,
    input  logic            i_issue_regwrite,
    input  logic [LW-1:0]   i_issue_lat,
    input  logic [AW-1:0]   i_src_a,
    input  logic            i_src_a_used,
    input  logic [AW-1:0]   i_src_b,
    input  logic            i_src_b_used,
    input  logic            i_flush,
    output logic            o_stall,
    output logic [NREG-1:0] o_busy_vec,
    output logic [CW-1:0]   o_stall_count
);

    logic [NREG-1:0] w_busy;
    logic [NREG-1:0] w_load;
    logic            w_hazard;
    logic            w_accept;
    logic [CW-1:0]   r_stall_count;

    // A single OR of the three hazard terms: SrcA == SrcB on a busy register
    // still yields one stall cycle, never two counts.
    assign w_hazard = (i_src_a_used     & w_busy[i_src_a])
                    | (i_src_b_used     & w_busy[i_src_b])
                    | (i_issue_regwrite & w_busy[i_issue_rd]);

    assign o_stall  = i_issue_valid & ~i_flush & w_hazard;
    assign w_accept = i_issue_valid & ~o_stall & ~i_flush & i_issue_regwrite;

    for (genvar g = 0; g < NREG; g++) begin : g_entry
        // Zero latency is covered by forwarding, so no entry is created.
        assign w_load[g] = w_accept && (i_issue_rd == AW'(g)) && (i_issue_lat != '0);

        scoreboard_entry #(
            .CNT_W (LW)
        ) u_entry (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_load     (w_load[g]),
            .i_load_val (i_issue_lat),
            .o_busy     (w_busy[g])
        );
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_count <= '0;
        end else if (o_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CW'(1);
        end
    end

    assign o_busy_vec    = w_busy;
    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_interlock.sv
module tb_hazard_interlock;
    import pipe_pkg::*;

    localparam int TB_NREG = 8;
    localparam int TB_AW   = 3;
    localparam int TB_LW   = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                issue_valid;
    logic [TB_AW-1:0]    issue_rd;
    logic                issue_regwrite;
    logic [TB_LW-1:0]    issue_lat;
    logic [TB_AW-1:0]    src_a;
    logic                src_a_used;
    logic [TB_AW-1:0]    src_b;
    logic                src_b_used;
    logic                flush;

    logic                stall;
    logic [TB_NREG-1:0]  busy_vec;
    logic [15:0]         stall_count;
    logic                stall_s;
    logic [TB_NREG-1:0]  busy_vec_s;
    logic [3:0]          stall_count_s;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each register remembers the edge index from which its
    // pending result is forwardable; busy while fewer edges have elapsed.
    int ready_at [TB_NREG];
    int edges        = 0;
    int stall_cycles = 0;

    always #5 clk = ~clk;

    hazard_interlock #(.NREG(TB_NREG), .AW(TB_AW), .LW(TB_LW), .CW(16)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
        .i_issue_regwrite(issue_regwrite), .i_issue_lat(issue_lat), .i_src_a(src_a),
        .i_src_a_used(src_a_used), .i_src_b(src_b), .i_src_b_used(src_b_used),
        .i_flush(flush), .o_stall(stall), .o_busy_vec(busy_vec), .o_stall_count(stall_count)
    );

    hazard_interlock #(.NREG(TB_NREG), .AW(TB_AW), .LW(TB_LW), .CW(4)) u_dut_sat (
        .i_clk(clk), .i_reset(reset), .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
        .i_issue_regwrite(issue_regwrite), .i_issue_lat(issue_lat), .i_src_a(src_a),
        .i_src_a_used(src_a_used), .i_src_b(src_b), .i_src_b_used(src_b_used),
        .i_flush(flush), .o_stall(stall_s), .o_busy_vec(busy_vec_s), .o_stall_count(stall_count_s)
    );

    function automatic logic m_busy(int r);
        return edges < ready_at[r];
    endfunction

    function automatic logic [TB_NREG-1:0] m_busy_vec();
        logic [TB_NREG-1:0] v;
        for (int r = 0; r < TB_NREG; r++) v[r] = m_busy(r);
        return v;
    endfunction

    function automatic logic m_stall();
        logic haz;
        haz = (src_a_used && m_busy(int'(src_a))) || (src_b_used && m_busy(int'(src_b)))
           || (issue_regwrite && m_busy(int'(issue_rd)));
        return issue_valid && !flush && haz;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < TB_NREG; r++) ready_at[r] = 0;
        stall_cycles = 0;
    endtask

    task automatic drive(input logic v, input int rd, input logic rw, input int lat,
                         input int a, input logic au, input int b, input logic bu,
                         input logic fl);
        issue_valid    = v;
        issue_rd       = TB_AW'(rd);
        issue_regwrite = rw;
        issue_lat      = TB_LW'(lat);
        src_a          = TB_AW'(a);
        src_a_used     = au;
        src_b          = TB_AW'(b);
        src_b_used     = bu;
        flush          = fl;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Called just after a negedge with inputs already driven: compares all
    // outputs with the model, then advances the model across the next posedge.
    task automatic check_cycle(input string tag);
        logic               exp_stall;
        logic               exp_accept;
        logic [TB_NREG-1:0] exp_vec;
        logic [15:0]        exp_cnt;
        logic [3:0]         exp_cnt_s;
        #1;
        if (reset) model_reset();
        exp_stall  = m_stall();
        exp_accept = issue_valid && !exp_stall && !flush && issue_regwrite;
        exp_vec    = m_busy_vec();
        exp_cnt    = (stall_cycles > 65535) ? 16'hFFFF : 16'(stall_cycles);
        exp_cnt_s  = (stall_cycles > 15) ? 4'hF : 4'(stall_cycles);

        n_checks++;
        if (stall !== exp_stall) begin
            n_errors++;
            $display("FAIL %s stall: got %b expected %b (t=%0t)", tag, stall, exp_stall, $time);
        end
        n_checks++;
        if (busy_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL %s busy_vec: got %b expected %b (t=%0t)", tag, busy_vec, exp_vec, $time);
        end
        n_checks++;
        if (stall_count !== exp_cnt) begin
            n_errors++;
            $display("FAIL %s stall_count: got %0d expected %0d (t=%0t)", tag, stall_count, exp_cnt, $time);
        end
        n_checks++;
        if (stall_s !== exp_stall || busy_vec_s !== exp_vec) begin
            n_errors++;
            $display("FAIL %s cw4 stall/busy: got %b/%b expected %b/%b", tag, stall_s, busy_vec_s, exp_stall, exp_vec);
        end
        n_checks++;
        if (stall_count_s !== exp_cnt_s) begin
            n_errors++;
            $display("FAIL %s cw4 stall_count: got %0d expected %0d (t=%0t)", tag, stall_count_s, exp_cnt_s, $time);
        end

        @(posedge clk);
        if (!reset) begin
            edges++;
            if (exp_accept && issue_lat != 0) ready_at[issue_rd] = edges + int'(issue_lat);
            if (exp_stall) stall_cycles++;
        end
        @(negedge clk);
    endtask

    task automatic expect_bit(input string tag, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        check_cycle("reset_idle");
        check_cycle("reset_idle2");
        reset = 1'b0;
        check_cycle("post_reset");
        // Build a stall on r3 (cnt=2), then reset asynchronously mid-cycle.
        drive(1'b1, 3, 1'b1, 2, 0, 1'b0, 0, 1'b0, 1'b0);
        check_cycle("reset_load_r3");
        drive(1'b1, 0, 1'b0, 0, 3, 1'b1, 0, 1'b0, 1'b0);
        #1;
        expect_bit("reset_pre_stall", stall, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        expect_bit("reset_async_stall", stall, 1'b0);
        expect_bit("reset_async_busy", |busy_vec, 1'b0);
        expect_bit("reset_async_count", |stall_count, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle();
        check_cycle("reset_release");
    endtask

    task automatic test_raw_latency();
        logic [15:0] cnt_before;
        logic        exp_seq [3] = '{1'b1, 1'b1, 1'b0};
        idle();
        check_cycle("raw_idle");
        cnt_before = stall_count;
        drive(1'b1, 3, 1'b1, 2, 0, 1'b0, 0, 1'b0, 1'b0);
        check_cycle("raw_load");
        drive(1'b1, 0, 1'b0, 0, 3, 1'b1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            expect_bit($sformatf("raw_seq%0d", i), stall, exp_seq[i]);
            check_cycle("raw_wait");
        end
        n_checks++;
        if (stall_count - cnt_before !== 16'd2) begin
            n_errors++;
            $display("FAIL raw_count_delta: got %0d expected 2", stall_count - cnt_before);
        end
        idle();
        check_cycle("raw_done");
    endtask

    task automatic test_lat_zero();
        drive(1'b1, 5, 1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        check_cycle("lat0_issue");
        drive(1'b1, 0, 1'b0, 0, 0, 1'b0, 5, 1'b1, 1'b0);
        #1;
        expect_bit("lat0_stall", stall, 1'b0);
        expect_bit("lat0_busy5", busy_vec[5], 1'b0);
        check_cycle("lat0_consumer");
        idle();
    endtask

    task automatic test_waw();
        drive(1'b1, 2, 1'b1, 1, 0, 1'b0, 0, 1'b0, 1'b0);
        check_cycle("waw_load1");
        drive(1'b1, 2, 1'b1, 3, 0, 1'b0, 0, 1'b0, 1'b0);
        #1;
        expect_bit("waw_stall", stall, 1'b1);
        check_cycle("waw_stalled");
        #1;
        expect_bit("waw_release", stall, 1'b0);
        check_cycle("waw_accept");
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            expect_bit($sformatf("waw_busy2_%0d", i), busy_vec[2], 1'b1);
            check_cycle("waw_hold");
        end
        #1;
        expect_bit("waw_busy2_clear", busy_vec[2], 1'b0);
        check_cycle("waw_done");
    endtask

    task automatic test_flush();
        drive(1'b1, 4, 1'b1, 3, 0, 1'b0, 0, 1'b0, 1'b0);
        check_cycle("flush_load4");
        drive(1'b1, 6, 1'b1, 2, 4, 1'b1, 0, 1'b0, 1'b1);
        #1;
        expect_bit("flush_stall", stall, 1'b0);
        check_cycle("flush_cycle");
        idle();
        #1;
        expect_bit("flush_busy4", busy_vec[4], 1'b1);
        expect_bit("flush_busy6", busy_vec[6], 1'b0);
        check_cycle("flush_after1");
        #1;
        expect_bit("flush_busy4_b", busy_vec[4], 1'b1);
        check_cycle("flush_after2");
        #1;
        expect_bit("flush_busy4_clear", busy_vec[4], 1'b0);
        check_cycle("flush_after3");
    endtask

    task automatic test_saturation();
        for (int round = 0; round < 7; round++) begin
            drive(1'b1, 1, 1'b1, 3, 0, 1'b0, 0, 1'b0, 1'b0);
            check_cycle("sat_load");
            // SrcA == SrcB == busy register: one stall per cycle.
            drive(1'b1, 0, 1'b0, 0, 1, 1'b1, 1, 1'b1, 1'b0);
            for (int i = 0; i < 4; i++) check_cycle("sat_dep");
            idle();
        end
        n_checks++;
        if (stall_count_s !== 4'hF) begin
            n_errors++;
            $display("FAIL sat_cw4: got %h expected f", stall_count_s);
        end
        check_cycle("sat_idle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(3, 0) != 0), int'($urandom_range(7, 0)), $urandom_range(1, 0) == 1,
                  int'($urandom_range(3, 0)), int'($urandom_range(7, 0)), $urandom_range(1, 0) == 1,
                  int'($urandom_range(7, 0)), $urandom_range(1, 0) == 1, $urandom_range(9, 0) == 0);
            reset = ($urandom_range(99, 0) == 0);
            check_cycle("random");
        end
        reset = 1'b0;
        idle();
        check_cycle("random_end");
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        test_reset();
        test_raw_latency();
        test_lat_zero();
        test_waw();
        test_flush();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_interlock.md
Name: hazard_interlock

Overview:
- Consumer-side partner to the writeback forwarding path in the 4-stage pipeline.
- Forwarding covers results that have already reached writeback. This block covers results that have not: it scoreboards in-flight register writes and raises Stall when an issuing instruction depends on one.
- Sits in decode/issue and drives the pipeline-hold logic.
- Also reports a per-register busy vector and a saturating stall counter.

Parameters:
- NREG, 8, number of architectural registers.
- AW, 3, register address width.
- LW, 2, latency counter width (max in-flight latency 2^LW-1).
- CW, 16, stall counter width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IssueValid  in  1  instruction in decode is presenting for issue.
- IssueRd  in  AW  destination register of issuing instruction.
- IssueRegwrite  in  1  issuing instruction writes IssueRd.
- IssueLat  in  LW  cycles until its result is forwardable; 0 = forwardable next cycle, no entry created.
- SrcA  in  AW  first source register.
- SrcAUsed  in  1  SrcA is actually read.
- SrcB  in  AW  second source register.
- SrcBUsed  in  1  SrcB is actually read.
- Flush  in  1  kill the instruction currently in decode.
- Stall  out  1  hold decode/fetch this cycle (combinational).
- BusyVec  out  NREG  bit r = register r has a pending, not-yet-forwardable write.
- StallCount  out  CW  saturating count of stalled cycles.

Behaviour:
- State: one LW-bit down-counter cnt[r] per register, plus StallCount.
- busy[r] = (cnt[r] != 0).
- BusyVec is a direct register-derived view of busy[], with no input dependence.
- Reset (asynchronous, any time including mid-stall):
  - all cnt[r] = 0 and StallCount = 0;
  - hence BusyVec = 0 and Stall = 0 immediately;
  - in-flight entries are discarded.
- Stall = IssueValid & ~Flush & (hazard on any of):
  - RAW: SrcAUsed & busy[SrcA];
  - RAW: SrcBUsed & busy[SrcB];
  - WAW: IssueRegwrite & busy[IssueRd].
- Each edge, for every r with cnt[r] != 0: cnt[r] <= cnt[r] - 1. Counters never wrap below 0.
- Accept = IssueValid & ~Stall & ~Flush & IssueRegwrite.
  - On Accept with IssueLat != 0: cnt[IssueRd] <= IssueLat. The load overrides that register's decrement.
  - On Accept with IssueLat = 0: no entry is created; the forwarding path covers it.
- Flush suppresses both Stall and Accept for that cycle only. Existing counters keep decrementing, because older writes still complete.
- StallCount increments by 1 on each edge where Stall = 1, and holds at all-ones (saturates).
- Latency: an entry loaded at edge N with IssueLat = L is busy for cycles N+1 .. N+L. The same source issues without stall at cycle N+L+1.
- A stall on register r releases automatically when cnt[r] reaches 0. No external wake-up is needed.
- SrcA == SrcB == busy register: a single stall condition. There is no double counting in StallCount.
- IssueRd equal to a busy source of the same instruction: stalls, by RAW and WAW alike.

Decomposition:
- Shared package pipe_pkg: constants NREG, AW, LW, CW; a reg_addr_t typedef (AW bits).
- One sub-module, scoreboard_entry:
  - single LW-bit counter with load/decrement/async clear;
  - busy output;
  - instantiated NREG times.
- Stall decode, Accept decode, and StallCount stay in the top module.

Test Plan:
- Reset asserted mid-stall (cnt[3]=2, SrcA=3 issuing) -> Stall, BusyVec, StallCount all 0 immediately, before the next edge.
- Issue Rd=3, IssueLat=2 at edge N; next instruction SrcA=3 SrcAUsed=1 -> Stall=1 for cycles N+1, N+2; issues at N+3; StallCount=2.
- Issue Rd=5, IssueLat=0; next SrcB=5 -> Stall=0, BusyVec[5] never set.
- WAW: cnt[2]=1, issue IssueRegwrite=1 IssueRd=2, sources unused -> Stall=1 one cycle, then Accept reloads cnt[2]=IssueLat.
- Flush=1 while the instruction would stall on busy reg 4 (cnt=3) -> Stall=0, no entry created, cnt[4] still decrements 3->2.
- StallCount preloaded by holding a dependence for 2^CW+5 cycles (use CW=4 override) -> StallCount stops at 4'hF.
